multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 clock  input  1  single rising-edge clock for all state.
REQ-002 reset_n  input  1  reset, asynchronous and active-low.
REQ-003 opcode  input  6  instruction bits [31:26], taken from the instruction register output.
REQ-004 funct  input  6  instruction bits [5:0].
REQ-005 branchTaken  input  1  datapath unsigned-compare result, rs <= rt.
REQ-006 PCWrite, IorD, IRWrite, memWrite, memToReg, regWrite, regDst, ALUSrcA, jump, jumpReg  output  1 each  datapath control lines.
REQ-007 ALUSrcB, PCSrc  output  2 each  datapath mux selects.
REQ-008 ALUControl  output  5  ALU operation code.
REQ-009 state  output  4  current FSM state, for debug.
REQ-010 illegalOp  output  1  sticky flag: an undecoded instruction was seen.

Function
REQ-011 Mux encodings:
- IorD: 0 = PC, 1 = ALU result.
- ALUSrcA: 0 = PC, 1 = register A.
- ALUSrcB: 00 = register B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2.
- PCSrc: 00 = ALU result, 01 = jump target, 10 = register A (jr), 11 = branch target.
REQ-012 All outputs are Moore, decoded from state only. Exception: PCWrite in BRANCH equals branchTaken.
REQ-013 Any output not listed for a state is 0. ALUControl defaults to ALU_ADD.
REQ-014 FETCH(0): IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALU_ADD, PCSrc=00, PCWrite=1. Next state is DECODE.
REQ-015 DECODE(1): no writes. opcode/funct select the next state:
- lw/sw -> MEMADR
- R-type and, nor, not, add, rolv, rorv -> RTEXE
- R-type jr -> JR
- nori -> IEXE
- bleu -> BRANCH
- j -> JUMP
- jal -> JAL
- anything else -> ILLEGAL
REQ-016 MEMADR(2): ALUSrcA=1, ALUSrcB=10, ALU_ADD. Next state is MEMRD for lw, MEMWR for sw.
REQ-017 MEMRD(3): IorD=1, ALU operands held as in MEMADR. Next state is MEMWB.
REQ-018 MEMWB(4): regWrite=1, memToReg=1, regDst=0. Next state is FETCH.
REQ-019 MEMWR(5): IorD=1, memWrite=1, operands held as in MEMADR. Next state is FETCH.
REQ-020 RTEXE(6): ALUSrcA=1, ALUSrcB=00, ALUControl decoded from funct. Next state is RTWB.
REQ-021 RTWB(7): regWrite=1, regDst=1, memToReg=0, ALU inputs held as in RTEXE. Next state is FETCH.
REQ-022 IEXE(8): ALUSrcA=1, ALUSrcB=10, ALU_NORI. Next state is IWB.
REQ-023 IWB(9): regWrite=1, regDst=0, memToReg=0, IEXE operands held. Next state is FETCH.
REQ-024 BRANCH(10): ALUSrcA=1, ALUSrcB=00, ALU_BLEU, PCSrc=11, PCWrite=branchTaken. Next state is FETCH.
REQ-025 JUMP(11): PCSrc=01, PCWrite=1. Next state is FETCH.
REQ-026 JR(12): jumpReg=1, PCSrc=10, PCWrite=1. Next state is FETCH.
REQ-027 JAL(13): jump=1 (write address 31), regWrite=1, memToReg=0, ALUSrcA=0, ALU_PASSA, PCSrc=01, PCWrite=1. The register write uses the PC value before the update, i.e. PC+4. Next state is FETCH.
REQ-028 ILLEGAL(14): sets illegalOp and writes nothing. Next state is FETCH.
REQ-029 illegalOp stays set until reset_n is asserted.
REQ-030 State 15 is unreachable; if entered, the next state is FETCH.
REQ-031 Cycles per instruction, FETCH included:
- lw 5
- sw, R-type, nori 4
- bleu, j, jal, jr 3
- illegal 3
REQ-032 IRWrite is asserted only in FETCH, so opcode/funct are stable from DECODE onward.

Reset
REQ-033 When reset_n is low, state becomes FETCH immediately, asynchronously, and illegalOp clears.
REQ-034 During reset the outputs show the FETCH decode. No write takes effect while reset_n is low.
REQ-035 Reset asserted in mid-instruction abandons that instruction.
REQ-036 The first rising edge after reset_n deasserts completes FETCH.

Structure
REQ-037 Shared package mc_pkg holds:
- the state enum and its 4-bit encoding
- opcode constants: RTYPE 000000, J 000010, JAL 000011, BLEU 000110, NORI 001110, LW 100011, SW 101011
- funct constants: ADD 100000, AND 100100, NOR 100111, NOT 101000, ROLV 000100, RORV 000110, JR 001000
- 5-bit ALU codes: ADD 00000, AND 00001, NOR 00010, NOT 00011, ROLV 00100, RORV 00101, BLEU 00110, NORI 00111, PASSA 01000
REQ-038 The funct-to-ALUControl decode is one sub-module, alu_decode. The FSM and the output decode stay in multicycle_control.

Verification
REQ-039 Reset: pulse reset_n low mid-MEMRD -> state=0 asynchronously, illegalOp=0; after release, state sequence is 0,1.
REQ-040 lw (opcode 100011): state sequence 0,1,2,3,4,0. In MEMRD, IorD=1. In MEMWB, regWrite=1 and memToReg=1. Exactly one IRWrite pulse.
REQ-041 sw: state sequence 0,1,2,5,0. memWrite=1 for exactly one cycle; regWrite is never asserted.
REQ-042 bleu with branchTaken=0: PCWrite=0 in BRANCH. Repeat with branchTaken=1: PCWrite=1 and PCSrc=11.
REQ-043 R-type rorv (funct 000110): ALUControl=00101 in RTEXE and RTWB; regDst=1 in RTWB. jal: regWrite=1, jump=1, PCSrc=01 in one cycle.
REQ-044 opcode 111111: state 14, then illegalOp=1 and stays 1 across the next ten instructions; back to FETCH after 3 cycles.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcode/funct fields, ALU codes.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTEXE   = 4'd6,
    S_RTWB    = 4'd7,
    S_IEXE    = 4'd8,
    S_IWB     = 4'd9,
    S_BRANCH  = 4'd10,
    S_JUMP    = 4'd11,
    S_JR      = 4'd12,
    S_JAL     = 4'd13,
    S_ILLEGAL = 4'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BLEU  = 6'b000110;
  localparam logic [5:0] OP_NORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_NOT  = 6'b101000;
  localparam logic [5:0] FN_ROLV = 6'b000100;
  localparam logic [5:0] FN_RORV = 6'b000110;
  localparam logic [5:0] FN_JR   = 6'b001000;

  localparam logic [4:0] ALU_ADD   = 5'b00000;
  localparam logic [4:0] ALU_AND   = 5'b00001;
  localparam logic [4:0] ALU_NOR   = 5'b00010;
  localparam logic [4:0] ALU_NOT   = 5'b00011;
  localparam logic [4:0] ALU_ROLV  = 5'b00100;
  localparam logic [4:0] ALU_RORV  = 5'b00101;
  localparam logic [4:0] ALU_BLEU  = 5'b00110;
  localparam logic [4:0] ALU_NORI  = 5'b00111;
  localparam logic [4:0] ALU_PASSA = 5'b01000;

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle: instruction fields and compare result in, control lines out.
interface multicycle_control_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       branchTaken;
  logic       PCWrite, IorD, IRWrite, memWrite, memToReg, regWrite, regDst, ALUSrcA, jump, jumpReg;
  logic [1:0] ALUSrcB, PCSrc;
  logic [4:0] ALUControl;
  logic [3:0] state;
  logic       illegalOp;

  modport master (
    input  opcode, funct, branchTaken,
    output PCWrite, IorD, IRWrite, memWrite, memToReg, regWrite, regDst, ALUSrcA, jump, jumpReg,
    output ALUSrcB, PCSrc, ALUControl, state, illegalOp
  );

  modport slave (
    output opcode, funct, branchTaken,
    input  PCWrite, IorD, IRWrite, memWrite, memToReg, regWrite, regDst, ALUSrcA, jump, jumpReg,
    input  ALUSrcB, PCSrc, ALUControl, state, illegalOp
  );
endinterface

// File: rtl/alu_decode.sv
// R-type funct to ALU operation decode; legal flags the functs the RTEXE path supports.
module alu_decode
  import mc_pkg::*;
(
  input  logic [5:0] funct,
  output logic [4:0] alu_control,
  output logic       legal
);

  always_comb begin
    alu_control = ALU_ADD;
    legal       = 1'b1;
    case (funct)
      FN_ADD:  alu_control = ALU_ADD;
      FN_AND:  alu_control = ALU_AND;
      FN_NOR:  alu_control = ALU_NOR;
      FN_NOT:  alu_control = ALU_NOT;
      FN_ROLV: alu_control = ALU_ROLV;
      FN_RORV: alu_control = ALU_RORV;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM with Moore output decode and a sticky illegal-instruction flag.
module multicycle_control
  import mc_pkg::*;
(
  input  logic          clock,
  input  logic          reset_n,
  multicycle_control_if.master bus
);

  state_t     state_q, state_d;
  logic       illegal_q;
  logic [4:0] rt_alu;
  logic       rt_legal;

  alu_decode u_alu_decode (
    .funct       (bus.funct),
    .alu_control (rt_alu),
    .legal       (rt_legal)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_ILLEGAL) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE: begin
            if (bus.funct == FN_JR) state_d = S_JR;
            else if (rt_legal)      state_d = S_RTEXE;
            else                    state_d = S_ILLEGAL;
          end
          OP_NORI: state_d = S_IEXE;
          OP_BLEU: state_d = S_BRANCH;
          OP_J:    state_d = S_JUMP;
          OP_JAL:  state_d = S_JAL;
          default: state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: state_d = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_RTEXE:  state_d = S_RTWB;
      S_IEXE:   state_d = S_IWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // Output decode depends on state only, except PCWrite in BRANCH.
  always_comb begin
    bus.PCWrite    = 1'b0;
    bus.IorD       = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.memWrite   = 1'b0;
    bus.memToReg   = 1'b0;
    bus.regWrite   = 1'b0;
    bus.regDst     = 1'b0;
    bus.ALUSrcA    = 1'b0;
    bus.jump       = 1'b0;
    bus.jumpReg    = 1'b0;
    bus.ALUSrcB    = 2'b00;
    bus.PCSrc      = 2'b00;
    bus.ALUControl = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        bus.IRWrite = 1'b1;
        bus.ALUSrcB = 2'b01;
        bus.PCWrite = 1'b1;
      end
      S_MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        bus.IorD    = 1'b1;
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
      end
      S_MEMWB: begin
        bus.regWrite = 1'b1;
        bus.memToReg = 1'b1;
      end
      S_MEMWR: begin
        bus.IorD     = 1'b1;
        bus.memWrite = 1'b1;
        bus.ALUSrcA  = 1'b1;
        bus.ALUSrcB  = 2'b10;
      end
      S_RTEXE: begin
        bus.ALUSrcA    = 1'b1;
        bus.ALUControl = rt_alu;
      end
      S_RTWB: begin
        bus.regWrite   = 1'b1;
        bus.regDst     = 1'b1;
        bus.ALUSrcA    = 1'b1;
        bus.ALUControl = rt_alu;
      end
      S_IEXE: begin
        bus.ALUSrcA    = 1'b1;
        bus.ALUSrcB    = 2'b10;
        bus.ALUControl = ALU_NORI;
      end
      S_IWB: begin
        bus.regWrite   = 1'b1;
        bus.ALUSrcA    = 1'b1;
        bus.ALUSrcB    = 2'b10;
        bus.ALUControl = ALU_NORI;
      end
      S_BRANCH: begin
        bus.ALUSrcA    = 1'b1;
        bus.ALUControl = ALU_BLEU;
        bus.PCSrc      = 2'b11;
        bus.PCWrite    = bus.branchTaken;
      end
      S_JUMP: begin
        bus.PCSrc   = 2'b01;
        bus.PCWrite = 1'b1;
      end
      S_JR: begin
        bus.jumpReg = 1'b1;
        bus.PCSrc   = 2'b10;
        bus.PCWrite = 1'b1;
      end
      // ALU passes PC (already PC+4) through so the link write sees the pre-jump value.
      S_JAL: begin
        bus.jump       = 1'b1;
        bus.regWrite   = 1'b1;
        bus.ALUControl = ALU_PASSA;
        bus.PCSrc      = 2'b01;
        bus.PCWrite    = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.state     = state_q;
  assign bus.illegalOp = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: state sequences, per-state control lines, reset and illegal handling.
module tb_multicycle_control;

  logic clock = 1'b0;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, iord, irw, memw, m2r, regw, regdst, srca, jump, jumpreg, ill;
    logic [1:0] srcb, pcsrc;
    logic [4:0] aluc;
  } snap_t;

  snap_t tr [8];
  int    irw_cnt, memw_cnt, regw_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the DUT in FETCH; leaves the DUT at the next FETCH.
  task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input logic bt, input int n, input logic [3:0] exp [5]);
    bus.opcode      = op;
    bus.funct       = fn;
    bus.branchTaken = bt;
    irw_cnt = 0; memw_cnt = 0; regw_cnt = 0;
    for (int i = 0; i < n; i++) begin
      tr[i] = '{st: bus.state, pcw: bus.PCWrite, iord: bus.IorD, irw: bus.IRWrite,
                memw: bus.memWrite, m2r: bus.memToReg, regw: bus.regWrite, regdst: bus.regDst,
                srca: bus.ALUSrcA, jump: bus.jump, jumpreg: bus.jumpReg, ill: bus.illegalOp,
                srcb: bus.ALUSrcB, pcsrc: bus.PCSrc, aluc: bus.ALUControl};
      chk($sformatf("%s_state%0d", tag, i), 32'(tr[i].st), 32'(exp[i]));
      irw_cnt  += int'(bus.IRWrite);
      memw_cnt += int'(bus.memWrite);
      regw_cnt += int'(bus.regWrite);
      @(negedge clock);
    end
    chk($sformatf("%s_back_fetch", tag), 32'(bus.state), 32'd0);
  endtask

  initial begin
    bus.opcode = 6'b000000; bus.funct = 6'b100000; bus.branchTaken = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_ill", 32'(bus.illegalOp), 32'd0);
    chk("rst_irwrite", 32'(bus.IRWrite), 32'd1);
    chk("rst_alusrcb", 32'(bus.ALUSrcB), 32'd1);
    reset_n = 1'b1;

    // lw
    run_instr("lw", 6'b100011, 6'b000000, 1'b0, 5, '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4});
    chk("lw_fetch_pcw", 32'(tr[0].pcw), 32'd1);
    chk("lw_adr_srca", 32'(tr[2].srca), 32'd1);
    chk("lw_adr_srcb", 32'(tr[2].srcb), 32'd2);
    chk("lw_rd_iord", 32'(tr[3].iord), 32'd1);
    chk("lw_rd_srcb", 32'(tr[3].srcb), 32'd2);
    chk("lw_wb_regw", 32'(tr[4].regw), 32'd1);
    chk("lw_wb_m2r", 32'(tr[4].m2r), 32'd1);
    chk("lw_wb_regdst", 32'(tr[4].regdst), 32'd0);
    chk("lw_irw_cnt", 32'(irw_cnt), 32'd1);

    // sw
    run_instr("sw", 6'b101011, 6'b000000, 1'b0, 4, '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0});
    chk("sw_memw_cnt", 32'(memw_cnt), 32'd1);
    chk("sw_regw_cnt", 32'(regw_cnt), 32'd0);
    chk("sw_wr_iord", 32'(tr[3].iord), 32'd1);

    // bleu not taken / taken
    run_instr("bleu0", 6'b000110, 6'b000000, 1'b0, 3, '{4'd0, 4'd1, 4'd10, 4'd0, 4'd0});
    chk("bleu0_pcw", 32'(tr[2].pcw), 32'd0);
    chk("bleu0_alu", 32'(tr[2].aluc), 32'd6);
    run_instr("bleu1", 6'b000110, 6'b000000, 1'b1, 3, '{4'd0, 4'd1, 4'd10, 4'd0, 4'd0});
    chk("bleu1_pcw", 32'(tr[2].pcw), 32'd1);
    chk("bleu1_pcsrc", 32'(tr[2].pcsrc), 32'd3);
    chk("bleu1_srca", 32'(tr[2].srca), 32'd1);

    // rorv
    run_instr("rorv", 6'b000000, 6'b000110, 1'b0, 4, '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0});
    chk("rorv_exe_alu", 32'(tr[2].aluc), 32'd5);
    chk("rorv_wb_alu", 32'(tr[3].aluc), 32'd5);
    chk("rorv_wb_regdst", 32'(tr[3].regdst), 32'd1);
    chk("rorv_wb_regw", 32'(tr[3].regw), 32'd1);
    chk("rorv_exe_srcb", 32'(tr[2].srcb), 32'd0);

    // and
    run_instr("and", 6'b000000, 6'b100100, 1'b0, 4, '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0});
    chk("and_exe_alu", 32'(tr[2].aluc), 32'd1);

    // jal
    run_instr("jal", 6'b000011, 6'b000000, 1'b0, 3, '{4'd0, 4'd1, 4'd13, 4'd0, 4'd0});
    chk("jal_regw", 32'(tr[2].regw), 32'd1);
    chk("jal_jump", 32'(tr[2].jump), 32'd1);
    chk("jal_pcsrc", 32'(tr[2].pcsrc), 32'd1);
    chk("jal_pcw", 32'(tr[2].pcw), 32'd1);
    chk("jal_alu", 32'(tr[2].aluc), 32'd8);
    chk("jal_m2r", 32'(tr[2].m2r), 32'd0);

    // jr and j
    run_instr("jr", 6'b000000, 6'b001000, 1'b0, 3, '{4'd0, 4'd1, 4'd12, 4'd0, 4'd0});
    chk("jr_jumpreg", 32'(tr[2].jumpreg), 32'd1);
    chk("jr_pcsrc", 32'(tr[2].pcsrc), 32'd2);
    run_instr("j", 6'b000010, 6'b000000, 1'b0, 3, '{4'd0, 4'd1, 4'd11, 4'd0, 4'd0});
    chk("j_pcsrc", 32'(tr[2].pcsrc), 32'd1);
    chk("j_jump", 32'(tr[2].jump), 32'd0);

    // nori
    run_instr("nori", 6'b001110, 6'b000000, 1'b0, 4, '{4'd0, 4'd1, 4'd8, 4'd9, 4'd0});
    chk("nori_exe_alu", 32'(tr[2].aluc), 32'd7);
    chk("nori_exe_srcb", 32'(tr[2].srcb), 32'd2);
    chk("nori_wb_regw", 32'(tr[3].regw), 32'd1);
    chk("nori_wb_regdst", 32'(tr[3].regdst), 32'd0);

    // undecoded R-type funct, before the flag is set
    run_instr("badfn", 6'b000000, 6'b111111, 1'b0, 3, '{4'd0, 4'd1, 4'd14, 4'd0, 4'd0});
    chk("badfn_regw_cnt", 32'(regw_cnt), 32'd0);
    chk("badfn_ill", 32'(bus.illegalOp), 32'd1);

    // reset to clear, then illegal opcode and sticky flag
    reset_n = 1'b0;
    #1 chk("clr_ill", 32'(bus.illegalOp), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    run_instr("ill", 6'b111111, 6'b000000, 1'b0, 3, '{4'd0, 4'd1, 4'd14, 4'd0, 4'd0});
    chk("ill_flag", 32'(bus.illegalOp), 32'd1);
    for (int k = 0; k < 10; k++) begin
      run_instr($sformatf("after%0d", k), 6'b000010, 6'b000000, 1'b0, 3,
                '{4'd0, 4'd1, 4'd11, 4'd0, 4'd0});
      chk($sformatf("sticky%0d", k), 32'(bus.illegalOp), 32'd1);
    end

    // reset asserted mid-MEMRD
    bus.opcode = 6'b100011;
    repeat (3) @(negedge clock);
    chk("mid_memrd", 32'(bus.state), 32'd3);
    #2 reset_n = 1'b0;
    #1 chk("async_state", 32'(bus.state), 32'd0);
    chk("async_ill", 32'(bus.illegalOp), 32'd0);
    @(negedge clock);
    chk("held_state", 32'(bus.state), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("post_rst_decode", 32'(bus.state), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
